// File: rtl/settle_arbiter.sv
// Round-robin arbiter that time-shares one combinational datapath between N_REQ
// requesters, waiting SETTLE cycles before sampling the result and returning it tagged.
module settle_arbiter #(
   parameter int N_REQ  = 4,
   parameter int DATA_W = 8,
   parameter int SETTLE = 2,
   parameter int ID_W   = $clog2(N_REQ)
) (
   input  logic                      clk,
   input  logic                      rst_n,
   input  logic [N_REQ-1:0]          req_valid,
   input  logic [N_REQ*DATA_W-1:0]   req_data,
   output logic [N_REQ-1:0]          req_ready,
   output logic [DATA_W-1:0]         dp_in,
   input  logic [DATA_W-1:0]         dp_out,
   output logic                      rsp_valid,
   output logic [ID_W-1:0]           rsp_id,
   output logic [DATA_W-1:0]         rsp_data,
   input  logic                      rsp_ready,
   output logic                      busy
);

   localparam int CNT_W = (SETTLE > 1) ? $clog2(SETTLE) : 1;

   typedef enum logic [1:0] {
      S_IDLE,
      S_SETTLE,
      S_RESP
   } state_e;

   state_e              state_q;
   logic [ID_W-1:0]     ptr_q;
   logic [ID_W-1:0]     ptr_d;
   logic [CNT_W-1:0]    cnt_q;
   logic [DATA_W-1:0]   dp_in_q;
   logic                rsp_valid_q;
   logic [ID_W-1:0]     rsp_id_q;
   logic [DATA_W-1:0]   rsp_data_q;
   logic                busy_q;

   logic [ID_W-1:0]     grant_idx;
   logic                grant_vld;
   logic                accept;

   // Search upward from ptr_q, wrapping, for the first valid requester.
   always_comb begin : grant_search
      int idx;
      // NOTE: every combinational output gets a default first so no path infers a latch.
      idx       = 0;
      grant_vld = 1'b0;
      grant_idx = '0;
      for (int k = 0; k < N_REQ; k++) begin
         idx = int'(ptr_q) + k;
         if (idx >= N_REQ) idx = idx - N_REQ;
         if (!grant_vld && req_valid[idx]) begin
            grant_vld = 1'b1;
            grant_idx = ID_W'(idx);
         end
      end
   end

   assign ptr_d  = (grant_idx == ID_W'(N_REQ - 1)) ? '0 : grant_idx + ID_W'(1);
   assign accept = (state_q == S_IDLE) && grant_vld;

   // Gated by rst_n so no requester sees a grant while the block is held in reset.
   always_comb begin
      req_ready = '0;
      if (rst_n && accept) req_ready[grant_idx] = 1'b1;
   end

   // NOTE: sequential state uses non-blocking assignments only, so every register samples pre-edge values.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= S_IDLE;
         ptr_q       <= '0;
         cnt_q       <= '0;
         dp_in_q     <= '0;
         rsp_valid_q <= 1'b0;
         rsp_id_q    <= '0;
         rsp_data_q  <= '0;
         busy_q      <= 1'b0;
      end else begin
         case (state_q)
            S_IDLE: begin
               if (accept) begin
                  dp_in_q  <= req_data[int'(grant_idx)*DATA_W +: DATA_W];
                  rsp_id_q <= grant_idx;
                  ptr_q    <= ptr_d;
                  cnt_q    <= CNT_W'(SETTLE - 1);
                  busy_q   <= 1'b1;
                  state_q  <= S_SETTLE;
               end
            end
            S_SETTLE: begin
               if (cnt_q != '0) begin
                  cnt_q <= cnt_q - CNT_W'(1);
               end else begin
                  rsp_data_q  <= dp_out;
                  rsp_valid_q <= 1'b1;
                  state_q     <= S_RESP;
               end
            end
            S_RESP: begin
               if (rsp_ready) begin
                  rsp_valid_q <= 1'b0;
                  busy_q      <= 1'b0;
                  state_q     <= S_IDLE;
               end
            end
            default: begin
               rsp_valid_q <= 1'b0;
               busy_q      <= 1'b0;
               state_q     <= S_IDLE;
            end
         endcase
      end
   end

   assign dp_in     = dp_in_q;
   assign rsp_valid = rsp_valid_q;
   assign rsp_id    = rsp_id_q;
   assign rsp_data  = rsp_data_q;
   assign busy      = busy_q;

endmodule

// File: tb/tb_settle_arbiter.sv
// Directed bench for settle_arbiter: the shared datapath is modelled as dp_out = ~dp_in,
// and every expected value below is hand-derived from the intended timing.
module tb_settle_arbiter;

   localparam int N_REQ  = 4;
   localparam int DATA_W = 8;
   localparam int SETTLE = 2;
   localparam int ID_W   = 2;

   logic                     clk = 1'b0;
   logic                     rst_n = 1'b0;
   logic [N_REQ-1:0]         req_valid = '0;
   logic [N_REQ*DATA_W-1:0]  req_data = '0;
   logic [N_REQ-1:0]         req_ready;
   logic [DATA_W-1:0]        dp_in;
   logic [DATA_W-1:0]        dp_out;
   logic                     rsp_valid;
   logic [ID_W-1:0]          rsp_id;
   logic [DATA_W-1:0]        rsp_data;
   logic                     rsp_ready = 1'b0;
   logic                     busy;

   int errors = 0;
   int checks = 0;

   settle_arbiter #(
      .N_REQ (N_REQ),
      .DATA_W(DATA_W),
      .SETTLE(SETTLE),
      .ID_W  (ID_W)
   ) dut (
      .clk      (clk),
      .rst_n    (rst_n),
      .req_valid(req_valid),
      .req_data (req_data),
      .req_ready(req_ready),
      .dp_in    (dp_in),
      .dp_out   (dp_out),
      .rsp_valid(rsp_valid),
      .rsp_id   (rsp_id),
      .rsp_data (rsp_data),
      .rsp_ready(rsp_ready),
      .busy     (busy)
   );

   assign dp_out = ~dp_in;

   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL watchdog: simulation still running at %0t, expected completion", $time);
      $fatal(1);
   end

   // Inputs change and outputs are sampled 1 time unit after a rising edge.
   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      rst_n     = 1'b0;
      req_valid = '0;
      rsp_ready = 1'b0;
      step();
      step();
      rst_n = 1'b1;
      #1;
   endtask

   task automatic test_reset();
      rst_n     = 1'b0;
      req_valid = 4'b1111;
      req_data  = {8'h44, 8'h33, 8'h22, 8'h11};
      step();
      step();
      checks++; if (req_ready !== 4'b0000) begin errors++; $display("FAIL reset_req_ready: got %b expected %b", req_ready, 4'b0000); end
      checks++; if (rsp_valid !== 1'b0) begin errors++; $display("FAIL reset_rsp_valid: got %b expected 0", rsp_valid); end
      checks++; if (dp_in !== 8'h00) begin errors++; $display("FAIL reset_dp_in: got %h expected 00", dp_in); end
      checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b expected 0", busy); end
      checks++; if (rsp_id !== 2'd0 || rsp_data !== 8'h00) begin errors++; $display("FAIL reset_rsp_regs: got id=%0d data=%h expected id=0 data=00", rsp_id, rsp_data); end
      rst_n = 1'b1;
      #1;
      checks++; if (req_ready !== 4'b0001) begin errors++; $display("FAIL reset_first_grant: got %b expected %b", req_ready, 4'b0001); end
      req_valid = '0;
      step();
   endtask

   task automatic test_single();
      req_data  = {8'h00, 8'h3C, 8'h00, 8'h00};
      req_valid = 4'b0100;
      rsp_ready = 1'b0;
      #1;
      checks++; if (req_ready !== 4'b0100) begin errors++; $display("FAIL single_grant: got %b expected %b", req_ready, 4'b0100); end
      step();  // E0
      req_valid = '0;
      #1;
      checks++; if (dp_in !== 8'h3C) begin errors++; $display("FAIL single_dp_in: got %h expected 3c", dp_in); end
      checks++; if (busy !== 1'b1 || req_ready !== 4'b0000 || rsp_valid !== 1'b0) begin errors++; $display("FAIL single_settle: got busy=%b ready=%b rsp_valid=%b expected 1 0000 0", busy, req_ready, rsp_valid); end
      step();  // E0+1
      checks++; if (rsp_valid !== 1'b0) begin errors++; $display("FAIL single_early_rsp: got %b expected 0", rsp_valid); end
      step();  // E0+2
      checks++; if (rsp_valid !== 1'b1 || rsp_id !== 2'd2 || rsp_data !== 8'hC3) begin errors++; $display("FAIL single_rsp: got v=%b id=%0d data=%h expected v=1 id=2 data=c3", rsp_valid, rsp_id, rsp_data); end
      rsp_ready = 1'b1;
      step();
      checks++; if (rsp_valid !== 1'b0 || busy !== 1'b0) begin errors++; $display("FAIL single_handshake: got v=%b busy=%b expected 0 0", rsp_valid, busy); end
      rsp_ready = 1'b0;
   endtask

   task automatic test_fairness();
      logic [7:0] d [4];
      int exp_g [5];
      logic [3:0] exp_rr;
      d     = '{8'h11, 8'h22, 8'h33, 8'h44};
      exp_g = '{0, 1, 2, 3, 0};
      do_reset();
      req_data  = {d[3], d[2], d[1], d[0]};
      req_valid = 4'b1111;
      rsp_ready = 1'b1;
      #1;
      for (int c = 0; c < 20; c++) begin
         exp_rr = (c % 4 == 0) ? (4'b0001 << exp_g[c / 4]) : 4'b0000;
         checks++; if (req_ready !== exp_rr) begin errors++; $display("FAIL fair_ready c=%0d: got %b expected %b", c, req_ready, exp_rr); end
         if (c % 4 == 3) begin
            checks++;
            if (rsp_valid !== 1'b1 || rsp_id !== ID_W'(exp_g[c / 4]) || rsp_data !== ~d[exp_g[c / 4]]) begin
               errors++;
               $display("FAIL fair_rsp c=%0d: got v=%b id=%0d data=%h expected v=1 id=%0d data=%h", c, rsp_valid, rsp_id, rsp_data, exp_g[c / 4], ~d[exp_g[c / 4]]);
            end
         end else begin
            checks++; if (rsp_valid !== 1'b0) begin errors++; $display("FAIL fair_no_rsp c=%0d: got %b expected 0", c, rsp_valid); end
         end
         step();
      end
      req_valid = '0;
      rsp_ready = 1'b0;
   endtask

   // Pointer sits at 1 after test_fairness, so requester 1 wins first.
   task automatic test_backpressure();
      req_data  = {8'h00, 8'h00, 8'h5A, 8'h00};
      req_valid = 4'b0010;
      rsp_ready = 1'b0;
      #1;
      checks++; if (req_ready !== 4'b0010) begin errors++; $display("FAIL bp_grant: got %b expected %b", req_ready, 4'b0010); end
      step();  // E0
      req_valid = 4'b1111;
      #1;
      checks++; if (req_ready !== 4'b0000 || dp_in !== 8'h5A) begin errors++; $display("FAIL bp_accept: got ready=%b dp_in=%h expected 0000 5a", req_ready, dp_in); end
      step();
      step();  // E0+2
      for (int i = 0; i < 5; i++) begin
         checks++;
         if (rsp_valid !== 1'b1 || rsp_id !== 2'd1 || rsp_data !== 8'hA5 || dp_in !== 8'h5A || req_ready !== 4'b0000 || busy !== 1'b1) begin
            errors++;
            $display("FAIL bp_hold i=%0d: got v=%b id=%0d data=%h dp_in=%h ready=%b busy=%b expected 1 1 a5 5a 0000 1", i, rsp_valid, rsp_id, rsp_data, dp_in, req_ready, busy);
         end
         step();
      end
      rsp_ready = 1'b1;
      #1;
      checks++; if (rsp_valid !== 1'b1 || req_ready !== 4'b0000) begin errors++; $display("FAIL bp_release: got v=%b ready=%b expected 1 0000", rsp_valid, req_ready); end
      step();
      checks++; if (rsp_valid !== 1'b0 || busy !== 1'b0 || req_ready !== 4'b0100) begin errors++; $display("FAIL bp_next_grant: got v=%b busy=%b ready=%b expected 0 0 0100", rsp_valid, busy, req_ready); end
      req_valid = '0;
      rsp_ready = 1'b0;
   endtask

   // Lone requester 2 twice (back-to-back), leaving ptr=3; then 1 and 3 alternate.
   task automatic test_wrap_skip();
      logic [7:0] d [4];
      int exp_g [5];
      logic [3:0] vld [5];
      d     = '{8'h00, 8'h81, 8'h02, 8'hF0};
      exp_g = '{2, 2, 3, 1, 3};
      vld   = '{4'b0100, 4'b0100, 4'b1010, 4'b1010, 4'b1010};
      do_reset();
      req_data  = {d[3], d[2], d[1], d[0]};
      rsp_ready = 1'b1;
      for (int t = 0; t < 5; t++) begin
         req_valid = vld[t];
         #1;
         checks++; if (req_ready !== (4'b0001 << exp_g[t])) begin errors++; $display("FAIL wrap_grant t=%0d: got %b expected %b", t, req_ready, 4'b0001 << exp_g[t]); end
         step();
         checks++; if (dp_in !== d[exp_g[t]]) begin errors++; $display("FAIL wrap_dp_in t=%0d: got %h expected %h", t, dp_in, d[exp_g[t]]); end
         step();
         step();
         checks++;
         if (rsp_valid !== 1'b1 || rsp_id !== ID_W'(exp_g[t]) || rsp_data !== ~d[exp_g[t]]) begin
            errors++;
            $display("FAIL wrap_rsp t=%0d: got v=%b id=%0d data=%h expected v=1 id=%0d data=%h", t, rsp_valid, rsp_id, rsp_data, exp_g[t], ~d[exp_g[t]]);
         end
         step();
      end
      req_valid = '0;
      rsp_ready = 1'b0;
   endtask

   task automatic test_reset_mid_settle();
      do_reset();
      req_data  = {8'h77, 8'h00, 8'h00, 8'h00};
      req_valid = 4'b1000;
      #1;
      checks++; if (req_ready !== 4'b1000) begin errors++; $display("FAIL rmid_grant: got %b expected %b", req_ready, 4'b1000); end
      step();  // E0
      checks++; if (dp_in !== 8'h77 || busy !== 1'b1) begin errors++; $display("FAIL rmid_accept: got dp_in=%h busy=%b expected 77 1", dp_in, busy); end
      req_valid = '0;
      step();  // E0+1
      rst_n = 1'b0;
      #1;
      checks++; if (dp_in !== 8'h00 || busy !== 1'b0 || rsp_valid !== 1'b0 || rsp_id !== 2'd0) begin errors++; $display("FAIL rmid_abort: got dp_in=%h busy=%b v=%b id=%0d expected 00 0 0 0", dp_in, busy, rsp_valid, rsp_id); end
      for (int i = 0; i < 3; i++) begin
         step();
         checks++; if (rsp_valid !== 1'b0) begin errors++; $display("FAIL rmid_no_rsp i=%0d: got %b expected 0", i, rsp_valid); end
      end
      rst_n     = 1'b1;
      req_data  = {8'h77, 8'h66, 8'h55, 8'h09};
      req_valid = 4'b1111;
      rsp_ready = 1'b1;
      #1;
      checks++; if (req_ready !== 4'b0001) begin errors++; $display("FAIL rmid_restart_grant: got %b expected %b", req_ready, 4'b0001); end
      step();
      req_valid = '0;
      step();
      step();
      checks++; if (rsp_valid !== 1'b1 || rsp_id !== 2'd0 || rsp_data !== 8'hF6) begin errors++; $display("FAIL rmid_restart_rsp: got v=%b id=%0d data=%h expected 1 0 f6", rsp_valid, rsp_id, rsp_data); end
      step();
      rsp_ready = 1'b0;
   endtask

   initial begin
      #1;
      test_reset();
      test_single();
      test_fairness();
      test_backpressure();
      test_wrap_skip();
      test_reset_mid_settle();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
